ablock_sweep_ctrl: RTL



---
 rtl/ablock_sweep_ctrl.sv | 72 +++++++
 1 files changed

// File: rtl/ablock_sweep_ctrl.sv
// ablock_sweep_ctrl: clocked exhaustive sweep of {a,b} over two AND instances with per-vector mismatch recording
module ablock_sweep_ctrl #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  output logic       a_out,
  output logic       b_out,
  input  logic       y0_in,
  input  logic       y1_in,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_mask0,
  output logic [3:0] err_mask1,
  output logic [3:0] err_cnt
);
  typedef enum logic [1:0] {IDLE, SETTLE, DONE} state_t;
  state_t state, state_n;
  logic [1:0] vec;
  logic [7:0] cnt;
  logic smp, exp_y, m0, m1;
  logic [3:0] cnt_n;
  always_comb begin
    smp = state == SETTLE && !abort && cnt == 8'd0;
    exp_y = vec[1] & vec[0];
    m0 = smp && (y0_in !== exp_y);
    m1 = smp && (y1_in !== exp_y);
    cnt_n = err_cnt + {3'b0, m0} + {3'b0, m1};
    state_n = state == IDLE ? (start ? SETTLE : IDLE) :
              state == SETTLE ? (abort ? IDLE : (smp && vec == 2'd3) ? DONE : SETTLE) :
              IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      vec <= '0;
      cnt <= '0;
      pass <= 1'b0;
      err_mask0 <= '0;
      err_mask1 <= '0;
      err_cnt <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && start) begin
        vec <= '0;
        cnt <= 8'(SETTLE_CYCLES - 1);
        pass <= 1'b0;
        err_mask0 <= '0;
        err_mask1 <= '0;
        err_cnt <= '0;
      end else if (state == SETTLE && !abort) begin
        if (cnt != 8'd0) begin
          cnt <= cnt - 8'd1;
        end else begin
          err_mask0 <= err_mask0 | ({3'b0, m0} << vec);
          err_mask1 <= err_mask1 | ({3'b0, m1} << vec);
          err_cnt <= cnt_n;
          vec <= vec + 2'd1;
          cnt <= 8'(SETTLE_CYCLES - 1);
          if (vec == 2'd3) pass <= cnt_n == 4'd0;
        end
      end
    end
  end
  assign busy = state == SETTLE;
  assign done = state == DONE;
  assign a_out = busy & vec[1];
  assign b_out = busy & vec[0];
endmodule
